trigger_timestamp_fifo: RTL
===========================

Name: trigger_timestamp_fifo

Overview:
- Sits directly upstream of the serial command processor.
- Produces the clockCounter / triggerFired pair the processor reads out on command 16, and consumes the processor's resetClock and resetOut strobes.
- Runs a free-running 56-bit tick counter. Each trigger fire is timestamped, and the timestamp plus trigger number is pushed into a small FIFO.
- The FIFO head is presented to the processor; each resetOut strobe pops one entry, so successive command-16 reads walk through buffered triggers in order.

Parameters:
- DEPTH, 8, number of FIFO entries (power of 2, >=2).
- CNT_W, 56, tick counter and timestamp width.
- TRIG_W, 8, trigger-number width.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- trigger_in  input  1  high for one or more cycles when the trigger logic fires; rising edge = one fire.
- trigger_id  input  TRIG_W  number of the trigger that fired; sampled on the trigger_in rising-edge cycle.
- resetClock  input  1  from processor; zero the tick counter.
- resetOut  input  1  from processor; rising edge pops the FIFO head.
- clockCounter  output  CNT_W  timestamp of FIFO head; 0 when empty.
- triggerFired  output  TRIG_W  trigger number of FIFO head; 0 when empty.
- fifo_count  output  $clog2(DEPTH)+1  number of stored entries.
- fifo_empty  output  1  fifo_count==0.
- overflow  output  1  sticky; set when a fire is dropped because the FIFO is full.

Behaviour:
- Reset values:
  - tick counter, rd_ptr, wr_ptr, fifo_count = 0
  - overflow = 0; fifo_empty = 1
  - clockCounter = 0; triggerFired = 0
  - edge-detect history registers = 0
  - FIFO contents need not be cleared.
- Tick counter:
  - Increments by 1 every cycle; wraps 2^CNT_W-1 -> 0 with no flag.
  - resetClock high in cycle N -> counter reads 0 in cycle N+1, then 1, 2, ...
  - resetClock has level semantics: the counter holds 0 while it stays high.
  - resetClock does not touch the FIFO or overflow.
- Fire detection:
  - push_req = trigger_in & ~trigger_in_d (one push per rising edge; a held-high input does not re-push).
  - Pushed entry = {counter value in the push_req cycle, trigger_id in that cycle}.
  - If resetClock is also high in that cycle, the pre-reset counter value is stored.
- Pop detection:
  - pop_req = resetOut & ~resetOut_d.
  - pop_req while empty is ignored, with no underflow flag.
- FIFO update, at the clock edge ending the request cycle:
  - push only, not full: write mem[wr_ptr]; wr_ptr+1 modulo DEPTH; count+1.
  - push only, full: drop the entry; overflow <= 1; pointers and count unchanged.
  - pop only, not empty: rd_ptr+1 modulo DEPTH; count-1.
  - push and pop in the same cycle, count >= 1: both execute; count unchanged; no overflow, even when full.
  - push and pop in the same cycle, empty: push executes, pop ignored; count becomes 1.
- Outputs:
  - clockCounter/triggerFired = mem[rd_ptr] when count > 0, else 0. Driven combinationally from registered state, so valid the cycle after the updating edge.
  - Push into an empty FIFO in cycle N -> head visible in cycle N+1.
  - The processor samples the head before it pulses resetOut, so the sampled head is never the popped one.
- overflow clears only on reset.
- Reset asserted mid-operation: all state returns to reset values on that edge; a push_req or pop_req in the same cycle is discarded.

Test Plan:
- Reset release, no fires, 100 cycles -> fifo_empty=1, clockCounter=0, triggerFired=0. Internal counter=100 (check via a later fire at cycle 100 -> head timestamp 100).
- Fires at counter=10 (id 2), 25 (id 5), 40 (id 2); then three resetOut pulses spaced 5 cycles -> heads read (10,2), (25,5), (40,2), then 0/0 with fifo_empty=1; fifo_count steps 3,2,1,0.
- trigger_in held high 20 cycles -> exactly one entry. resetClock at counter=500 -> next fire 7 cycles later stamps 6, where 6 = (reset in cycle N, 0 in N+1, fire in N+7).
- 9 fires with DEPTH=8 -> fifo_count=8, overflow=1, ninth entry absent. Then 8 pops -> first 8 timestamps in order; overflow remains 1.
- FIFO full, push_req and pop_req in the same cycle -> fifo_count stays 8, overflow stays 0, new entry appears after the 7 older ones.
- Counter preloaded via 2^56-3 cycles (force in sim) -> fires at wrap stamp 2^56-1 then 0. Reset asserted with 4 entries and a coincident fire -> fifo_count=0, overflow=0 next cycle.

Source files
------------

// File: rtl/trigger_timestamp_fifo_if.sv
// Trigger/processor-side signal bundle for trigger_timestamp_fifo.
// The master modport drives trigger and processor strobes, and the slave modport is the FIFO block.
interface trigger_timestamp_fifo_if #(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 56,
  parameter int TRIG_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              trigger_in;
  logic [TRIG_W-1:0] trigger_id;
  logic              resetClock;
  logic              resetOut;
  logic [CNT_W-1:0]  clockCounter;
  logic [TRIG_W-1:0] triggerFired;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              overflow;

  modport master (
    output trigger_in, trigger_id, resetClock, resetOut,
    input  clockCounter, triggerFired, fifo_count, fifo_empty, overflow
  );

  modport slave (
    input  trigger_in, trigger_id, resetClock, resetOut,
    output clockCounter, triggerFired, fifo_count, fifo_empty, overflow
  );
endinterface

// File: rtl/trigger_timestamp_fifo.sv
// Free-running tick counter that timestamps rising edges of trigger_in into a small FIFO.
// The processor reads the FIFO head, and each resetOut rising edge pops one entry.
module trigger_timestamp_fifo #(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 56,
  parameter int TRIG_W = 8
) (
  input logic                    clk,
  input logic                    reset,
  trigger_timestamp_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = CNT_W + TRIG_W;

  logic [CNT_W-1:0] r_tick;
  logic             r_trig_d;
  logic             r_rout_d;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic [EW-1:0]    r_mem [DEPTH];

  logic             w_push_req;
  logic             w_pop_req;
  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_drop;
  logic [EW-1:0]    w_head;

  assign w_push_req = bus.trigger_in & ~r_trig_d;
  assign w_pop_req  = bus.resetOut & ~r_rout_d;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_do_pop  = w_pop_req & ~w_empty;
  assign w_do_push = w_push_req & (~w_full | w_do_pop);
  assign w_drop    = w_push_req & w_full & ~w_do_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick     <= '0;
      r_trig_d   <= 1'b0;
      r_rout_d   <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_tick   <= bus.resetClock ? '0 : r_tick + CNT_W'(1);
      r_trig_d <= bus.trigger_in;
      r_rout_d <= bus.resetOut;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage is not cleared on reset; the outputs are gated by the count instead.
  always_ff @(posedge clk) begin
    if (!reset && w_do_push) r_mem[r_wr_ptr] <= {r_tick, bus.trigger_id};
  end

  assign w_head           = r_mem[r_rd_ptr];
  assign bus.clockCounter = w_empty ? '0 : w_head[EW-1:TRIG_W];
  assign bus.triggerFired = w_empty ? '0 : w_head[TRIG_W-1:0];
  assign bus.fifo_count   = r_count;
  assign bus.fifo_empty   = w_empty;
  assign bus.overflow     = r_overflow;
endmodule
